// File: rtl/seg_scan_display_pkg.sv
// Shared constants and width helpers for the multiplexed seven-segment display engine.
package seg_pkg;

  localparam logic [4:0] GLYPH_DASH       = 5'd16;
  localparam logic [4:0] GLYPH_UNDERSCORE = 5'd17;
  localparam logic [4:0] GLYPH_BLANK      = 5'd31;
  localparam logic [6:0] SEG_BLANK        = 7'h7F;

  // Counter width for a 0..range-1 counter; a one-state counter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/seg_scan_display_glyph.sv
// Glyph decoder: 5-bit code to active-low {g,f,e,d,c,b,a} segments.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      5'd0:             o_seg = 7'b1000000;
      5'd1:             o_seg = 7'b1111001;
      5'd2:             o_seg = 7'b0100100;
      5'd3:             o_seg = 7'b0110000;
      5'd4:             o_seg = 7'b0011001;
      5'd5:             o_seg = 7'b0010010;
      5'd6:             o_seg = 7'b0000010;
      5'd7:             o_seg = 7'b1111000;
      5'd8:             o_seg = 7'b0000000;
      5'd9:             o_seg = 7'b0010000;
      5'd10:            o_seg = 7'b0001000;
      5'd11:            o_seg = 7'b0000011;
      5'd12:            o_seg = 7'b1000110;
      5'd13:            o_seg = 7'b0100001;
      5'd14:            o_seg = 7'b0000110;
      5'd15:            o_seg = 7'b0001110;
      GLYPH_DASH:       o_seg = 7'b0111111;
      GLYPH_UNDERSCORE: o_seg = 7'b1110111;
      default:          o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan engine with frame-synchronous loading,
// per-digit blink, PWM brightness and a frame tick.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned BLINK_DIV  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [6:0]              digits,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   sel
);

  localparam int unsigned SW = cnt_width(SCAN_DIV);
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned FW = cnt_width(BLINK_DIV);
  localparam int unsigned TW = $clog2(SCAN_DIV) + 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] DUTY_STEP  = TW'(SCAN_DIV >> PWM_BITS);

  logic [SW-1:0]                 r_scan_cnt;
  logic [IW-1:0]                 r_idx;
  logic [FW-1:0]                 r_frame_cnt;
  logic                          r_blink_phase;
  logic [NUM_DIGITS-1:0][4:0]    r_pend_num, r_show_num;
  logic [NUM_DIGITS-1:0]         r_pend_dp, r_show_dp;
  logic [NUM_DIGITS-1:0]         r_pend_blink, r_show_blink;
  logic                          r_pending;
  logic                          r_frame_tick;
  logic [6:0]                    r_digits;
  logic                          r_dp_n;
  logic [NUM_DIGITS-1:0]         r_sel;

  logic                          w_scan_wrap;
  logic                          w_frame_bnd;
  logic                          w_commit;
  logic [4:0]                    w_code;
  logic [6:0]                    w_glyph;
  logic [TW-1:0]                 w_thr;
  logic                          w_lit;
  logic                          w_show;

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_frame_bnd = w_scan_wrap && (r_idx == IDX_LAST);
  assign w_commit    = w_frame_bnd && r_pending;
  assign w_code      = r_show_num[r_idx];
  assign w_thr       = (TW'(brightness) + TW'(1)) * DUTY_STEP;
  assign w_lit       = (TW'(r_scan_cnt) < w_thr);
  assign w_show      = w_lit && !(r_show_blink[r_idx] && r_blink_phase);

  seg_glyph u_glyph (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_pend_num    <= {NUM_DIGITS{GLYPH_BLANK}};
      r_pend_dp     <= '0;
      r_pend_blink  <= '0;
      r_show_num    <= {NUM_DIGITS{GLYPH_BLANK}};
      r_show_dp     <= '0;
      r_show_blink  <= '0;
      r_pending     <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_digits      <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_sel         <= '1;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
      if (w_scan_wrap)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      if (w_frame_bnd) begin
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
      // Commit takes the pre-load pend_* contents; a same-cycle load re-arms pending.
      if (w_commit) begin
        r_show_num   <= r_pend_num;
        r_show_dp    <= r_pend_dp;
        r_show_blink <= r_pend_blink;
      end
      if (load) begin
        r_pend_num   <= num;
        r_pend_dp    <= dp;
        r_pend_blink <= blink;
        r_pending    <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      r_frame_tick <= w_frame_bnd;
      r_sel        <= w_lit  ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_digits     <= w_show ? w_glyph : SEG_BLANK;
      r_dp_n       <= w_show ? ~r_show_dp[r_idx] : 1'b1;
    end
  end

  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;
  assign digits     = r_digits;
  assign dp_n       = r_dp_n;
  assign sel        = r_sel;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display at NUM_DIGITS=4, SCAN_DIV=16, PWM_BITS=2, BLINK_DIV=2.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [19:0] num;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic [1:0]  brightness;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  digits;
  logic        dp_n;
  logic [3:0]  sel;

  seg_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (16),
    .PWM_BITS   (2),
    .BLINK_DIV  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .num        (num),
    .dp         (dp),
    .blink      (blink),
    .brightness (brightness),
    .load       (load),
    .pending    (pending),
    .frame_tick (frame_tick),
    .digits     (digits),
    .dp_n       (dp_n),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [13:0] sb_q[$];

  // Reference state: m_t is the cycle index since reset; scan position is derived from it.
  int unsigned m_t;
  logic        m_pending;
  logic [19:0] m_pend_num, m_show_num;
  logic [3:0]  m_pend_dp, m_show_dp, m_pend_blink, m_show_blink;

  function automatic logic [6:0] ref_glyph(input logic [4:0] c);
    logic [6:0] hex [16];
    hex = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (c < 5'd16) return hex[c[3:0]];
    if (c == 5'd16) return 7'b0111111;
    if (c == 5'd17) return 7'b1110111;
    return 7'h7F;
  endfunction

  // Drives one clock with the given rst/load, pushing the expected post-edge outputs.
  task automatic cyc(input logic r, input logic ld);
    logic [13:0] e;
    int p, idx, sc;
    logic lit, blank, commit;
    rst  = r;
    load = ld;
    if (r) begin
      e = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
      m_t = 0; m_pending = 1'b0;
      m_pend_num = 20'hFFFFF; m_show_num = 20'hFFFFF;
      m_pend_dp = '0; m_show_dp = '0; m_pend_blink = '0; m_show_blink = '0;
    end else begin
      p = int'(m_t % 64); idx = p / 16; sc = p % 16;
      lit   = sc < 4 * (int'(brightness) + 1);
      blank = m_show_blink[idx] && ((m_t / 128) % 2 == 1);
      e = {4'hF, 7'h7F, 1'b1, (p == 63), 1'b0};
      if (lit) begin
        e[13:10] = ~(4'b0001 << idx);
        if (!blank) begin
          e[9:3] = ref_glyph(m_show_num[idx*5 +: 5]);
          e[2]   = ~m_show_dp[idx];
        end
      end
      commit = (p == 63) && m_pending;
      if (commit) begin
        m_show_num = m_pend_num; m_show_dp = m_pend_dp; m_show_blink = m_pend_blink;
      end
      if (ld) begin
        m_pend_num = num; m_pend_dp = dp; m_pend_blink = blink; m_pending = 1'b1;
      end else if (commit) begin
        m_pending = 1'b0;
      end
      e[0] = m_pending;
      m_t++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] act, exp;
    int cnt [4];
    int ticks, lit_glyph;
    cnt = '{0, 0, 0, 0}; ticks = 0; lit_glyph = 0;
    brightness = 2'd3;
    for (int k = 0; k < 66; k++) begin
      cyc(k < 2, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL reset_sb t=%0d got %h exp %h", m_t, act, exp); end
      if (k >= 2) begin
        for (int i = 0; i < 4; i++) if (sel === ~(4'b0001 << i)) cnt[i]++;
        if (frame_tick === 1'b1) ticks++;
        if (digits !== 7'h7F || dp_n !== 1'b1) lit_glyph++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cnt[i] != 16) begin n_bad++; $display("FAIL reset_sel%0d got %0d exp 16", i, cnt[i]); end
    end
    n_vec++;
    if (ticks != 1) begin n_bad++; $display("FAIL reset_ticks got %0d exp 1", ticks); end
    n_vec++;
    if (lit_glyph != 0) begin n_bad++; $display("FAIL reset_blank got %0d exp 0", lit_glyph); end
  endtask

  task automatic test_load_commit();
    logic [13:0] act, exp;
    logic [6:0] cap [4];
    logic [6:0] want [4];
    logic fell;
    want = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    cap  = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    fell = 1'b0;
    num = {5'd3, 5'd2, 5'd1, 5'd0}; dp = '0; blink = '0; brightness = 2'd3;
    cyc(1'b0, 1'b1);
    act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
    if (act !== exp) begin n_bad++; $display("FAIL load_sb t=%0d got %h exp %h", m_t, act, exp); end
    for (int k = 0; k < 100 && !fell; k++) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL load_sb t=%0d got %h exp %h", m_t, act, exp); end
      if (pending === 1'b0) fell = 1'b1;
    end
    n_vec++;
    if (!fell) begin n_bad++; $display("FAIL load_pending_fall got 1 exp 0 within 100 cycles"); end
    for (int k = 0; k < 64; k++) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL load_sb t=%0d got %h exp %h", m_t, act, exp); end
      for (int i = 0; i < 4; i++) if (sel === ~(4'b0001 << i)) cap[i] = digits;
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cap[i] !== want[i]) begin n_bad++; $display("FAIL load_digit%0d got %b exp %b", i, cap[i], want[i]); end
    end
  endtask

  task automatic test_boundary_load();
    logic [13:0] act, exp;
    logic [6:0] cap;
    num = {5'd7, 5'd6, 5'd5, 5'd4};
    cyc(1'b0, 1'b1);
    act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
    if (act !== exp) begin n_bad++; $display("FAIL bnd_sb t=%0d got %h exp %h", m_t, act, exp); end
    while (m_t % 64 != 63) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL bnd_sb t=%0d got %h exp %h", m_t, act, exp); end
    end
    num = {5'd12, 5'd11, 5'd10, 5'd9};
    cyc(1'b0, 1'b1);
    act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
    if (act !== exp) begin n_bad++; $display("FAIL bnd_sb t=%0d got %h exp %h", m_t, act, exp); end
    n_vec++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL bnd_pending got %b exp 1", pending); end
    for (int f = 0; f < 2; f++) begin
      cap = 7'h7F;
      for (int k = 0; k < 64; k++) begin
        cyc(1'b0, 1'b0);
        act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
        if (act !== exp) begin n_bad++; $display("FAIL bnd_sb t=%0d got %h exp %h", m_t, act, exp); end
        if (sel === 4'b1110) cap = digits;
      end
      n_vec++;
      if (cap !== ((f == 0) ? 7'b0011001 : 7'b0010000)) begin
        n_bad++; $display("FAIL bnd_frame%0d_digit0 got %b exp %b", f, cap, (f == 0) ? 7'b0011001 : 7'b0010000);
      end
    end
  endtask

  task automatic test_brightness();
    logic [13:0] act, exp;
    int on;
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 2'd0 : 2'd2;
      on = 0;
      for (int k = 0; k < 64; k++) begin
        cyc(1'b0, 1'b0);
        act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
        if (act !== exp) begin n_bad++; $display("FAIL bright_sb t=%0d got %h exp %h", m_t, act, exp); end
        if (sel !== 4'hF) on++;
      end
      n_vec++;
      if (on != ((b == 0) ? 16 : 48)) begin
        n_bad++; $display("FAIL bright%0d_on got %0d exp %0d", brightness, on, (b == 0) ? 16 : 48);
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_blink();
    logic [13:0] act, exp;
    int dash, d0_dp, d0_eight, d3_lit;
    dash = 0; d0_dp = 0; d0_eight = 0; d3_lit = 0;
    num = {5'd31, 5'd17, 5'd16, 5'd8}; dp = 4'b0001; blink = 4'b0010; brightness = 2'd3;
    cyc(1'b0, 1'b1);
    act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
    if (act !== exp) begin n_bad++; $display("FAIL blink_sb t=%0d got %h exp %h", m_t, act, exp); end
    for (int k = 0; k < 320; k++) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL blink_sb t=%0d got %h exp %h", m_t, act, exp); end
      if (k >= 64) begin
        if (sel === 4'b1101 && digits === 7'b0111111) dash++;
        if (sel === 4'b1110 && dp_n === 1'b0) d0_dp++;
        if (sel === 4'b1110 && digits === 7'b0000000) d0_eight++;
        if (sel === 4'b0111 && (digits !== 7'h7F || dp_n !== 1'b1)) d3_lit++;
      end
    end
    n_vec++;
    if (dash != 32) begin n_bad++; $display("FAIL blink_dash got %0d exp 32", dash); end
    n_vec++;
    if (d0_dp != 64) begin n_bad++; $display("FAIL blink_d0_dp got %0d exp 64", d0_dp); end
    n_vec++;
    if (d0_eight != 64) begin n_bad++; $display("FAIL blink_d0_eight got %0d exp 64", d0_eight); end
    n_vec++;
    if (d3_lit != 0) begin n_bad++; $display("FAIL blink_d3_blank got %0d exp 0", d3_lit); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] act, exp;
    int leaked, pend_hi;
    leaked = 0; pend_hi = 0;
    while (m_t % 64 != 20) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL rstmid_sb t=%0d got %h exp %h", m_t, act, exp); end
    end
    num = {5'd1, 5'd1, 5'd1, 5'd1}; dp = 4'hF; blink = '0;
    for (int k = 0; k < 5; k++) begin
      cyc(k == 4, k == 0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL rstmid_sb t=%0d got %h exp %h", m_t, act, exp); end
    end
    n_vec++;
    if ({sel, digits, dp_n, frame_tick, pending} !== 14'b1111_1111111_1_0_0) begin
      n_bad++; $display("FAIL rstmid_values got %b exp %b", {sel, digits, dp_n, frame_tick, pending}, 14'b1111_1111111_1_0_0);
    end
    for (int k = 0; k < 160; k++) begin
      cyc(1'b0, 1'b0);
      act = {sel, digits, dp_n, frame_tick, pending}; exp = sb_q.pop_front(); n_vec++;
      if (act !== exp) begin n_bad++; $display("FAIL rstmid_sb t=%0d got %h exp %h", m_t, act, exp); end
      if (digits !== 7'h7F || dp_n !== 1'b1) leaked++;
      if (pending !== 1'b0) pend_hi++;
    end
    n_vec++;
    if (leaked != 0) begin n_bad++; $display("FAIL rstmid_leak got %0d exp 0", leaked); end
    n_vec++;
    if (pend_hi != 0) begin n_bad++; $display("FAIL rstmid_pending got %0d exp 0", pend_hi); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; num = '0; dp = '0; blink = '0; brightness = 2'd3;
    @(negedge clk);
    test_reset();
    test_load_commit();
    test_boundary_load();
    test_brightness();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
